exc_tracker: RTL and testbench

Exception-tracking front end that feeds CP0 on the pipeline side. Carries per-instruction exception attributes through the D/E/M stage registers, picks the winning exception for each instruction, and presents it to CP0 at the M stage. On CP0's `exc_occur` it sequences the pipeline flush and the fetch redirect.

---
 rtl/exc_tracker.sv | 134 +++++++++++++
 tb/tb_exc_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_tracker.sv
// exc_tracker: carries exception attributes through D/E/M, presents the winner to CP0 and sequences flush/redirect.
// Optional ADDR_EXC_EN enables fetch-misalignment and data address (AdEL/AdES) exceptions.
module exc_tracker #(
  parameter logic [31:0] EXC_PC = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_is_in_ds,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        ex_ov,
  input  logic        ex_adel,
  input  logic        ex_ades,
  input  logic [31:0] ex_badvaddr,
  input  logic        pipe_stall,
  output logic [31:0] pre_pc,
  output logic [31:0] pre_badvaddr,
  output logic [4:0]  pre_excCode,
  output logic        pre_is_exc,
  output logic        pre_is_in_ds,
  output logic        pre_is_eret,
  output logic        reg_valid,
  output logic [31:0] cur_pc,
  output logic        cur_is_in_ds,
  input  logic        exc_occur,
  input  logic [31:0] cp0_pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);
`ifdef ADDR_EXC_EN
  localparam bit ADDR_EN = 1'b1;
`else
  localparam bit ADDR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        in_ds;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    logic        eret;
  } stage_t;
  state_t      r_state;
  stage_t      r_d, r_e, r_m;
  stage_t      w_d, w_e, w_m;
  logic        r_flush, r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        w_unused;
  assign w_unused = ^EXC_PC;
  // An exception already recorded in an earlier stage blocks every later flag.
  always_comb begin
    w_d          = '0;
    w_d.valid    = if_valid;
    w_d.pc       = if_pc;
    w_d.in_ds    = if_is_in_ds;
    w_d.exc      = ADDR_EN && (if_pc[1:0] != 2'b00);
    w_d.code     = w_d.exc ? 5'd4 : 5'd0;
    w_d.badvaddr = w_d.exc ? if_pc : 32'd0;
    w_e          = r_d;
    if (!r_d.exc && (id_ri || id_sys || id_bp)) begin
      w_e.exc  = 1'b1;
      w_e.code = id_ri ? 5'd10 : id_sys ? 5'd8 : 5'd9;
    end else if (!r_d.exc && id_eret) begin
      w_e.exc  = 1'b1;
      w_e.eret = 1'b1;
    end
    w_m = r_e;
    if (!r_e.exc && ex_ov) begin
      w_m.exc  = 1'b1;
      w_m.code = 5'd12;
    end else if (!r_e.exc && ADDR_EN && (ex_adel || ex_ades)) begin
      w_m.exc      = 1'b1;
      w_m.code     = ex_adel ? 5'd4 : 5'd5;
      w_m.badvaddr = ex_badvaddr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= RUN;
      r_d              <= '0;
      r_e              <= '0;
      r_m              <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      case (r_state)
        RUN:
          if (exc_occur && r_m.valid) begin
            r_state       <= FLUSH;
            r_d.valid     <= 1'b0;
            r_e.valid     <= 1'b0;
            r_m.valid     <= 1'b0;
            r_flush       <= 1'b1;
            r_redirect_pc <= cp0_pc;
          end else if (!pipe_stall) begin
            r_d <= w_d;
            r_e <= w_e;
            r_m <= w_m;
          end
        FLUSH: begin
          r_state          <= REDIRECT;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b1;
        end
        default:
          if (redirect_ready) begin
            r_state          <= RUN;
            r_redirect_valid <= 1'b0;
          end
      endcase
    end
  end
  assign pre_pc         = r_m.pc;
  assign pre_badvaddr   = r_m.badvaddr;
  assign pre_excCode    = r_m.code;
  assign pre_is_exc     = r_m.valid & r_m.exc;
  assign pre_is_in_ds   = r_m.in_ds;
  assign pre_is_eret    = r_m.valid & r_m.eret;
  assign reg_valid      = r_m.valid & (r_state == RUN);
  assign cur_pc         = r_m.pc;
  assign cur_is_in_ds   = r_m.in_ds;
  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_exc_tracker.sv
// tb_exc_tracker: directed and randomized checks of exc_tracker against a per-instruction priority model.
module tb_exc_tracker;
`ifdef ADDR_EXC_EN
  localparam bit AE = 1'b1;
`else
  localparam bit AE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, if_valid, if_is_in_ds, id_ri, id_sys, id_bp, id_eret;
  logic        ex_ov, ex_adel, ex_ades, pipe_stall, exc_occur, redirect_ready;
  logic [31:0] if_pc, ex_badvaddr, cp0_pc;
  logic [31:0] pre_pc, pre_badvaddr, cur_pc, redirect_pc;
  logic [4:0]  pre_excCode;
  logic        pre_is_exc, pre_is_in_ds, pre_is_eret, reg_valid, cur_is_in_ds;
  logic        flush, redirect_valid;
  int          checks = 0;
  int          failures = 0;

  exc_tracker dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_is_in_ds(if_is_in_ds),
    .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_eret(id_eret),
    .ex_ov(ex_ov), .ex_adel(ex_adel), .ex_ades(ex_ades), .ex_badvaddr(ex_badvaddr),
    .pipe_stall(pipe_stall), .pre_pc(pre_pc), .pre_badvaddr(pre_badvaddr),
    .pre_excCode(pre_excCode), .pre_is_exc(pre_is_exc), .pre_is_in_ds(pre_is_in_ds),
    .pre_is_eret(pre_is_eret), .reg_valid(reg_valid), .cur_pc(cur_pc),
    .cur_is_in_ds(cur_is_in_ds), .exc_occur(exc_occur), .cp0_pc(cp0_pc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // Each instruction collects the flags it saw at each stage; the winner is resolved only at M.
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        ds, ri, sys, bp, er, ov, adel, ades;
    bit [31:0] bad;
  } rec_t;
  rec_t        md, me, mm;
  int          ph;
  bit   [31:0] rpc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void resolve(input rec_t r, output bit exc, output bit [4:0] code,
                                  output bit [31:0] bad, output bit er);
    exc = 1'b1; er = 1'b0; code = 5'd0; bad = 32'd0;
    if (AE && r.pc[1:0] != 2'b00) begin code = 5'd4; bad = r.pc; end
    else if (r.ri) code = 5'd10;
    else if (r.sys) code = 5'd8;
    else if (r.bp) code = 5'd9;
    else if (r.er) er = 1'b1;
    else if (r.ov) code = 5'd12;
    else if (AE && r.adel) begin code = 5'd4; bad = r.bad; end
    else if (AE && r.ades) begin code = 5'd5; bad = r.bad; end
    else exc = 1'b0;
  endfunction

  task automatic model_edge();
    if (reset) begin
      md = '{default: '0}; me = '{default: '0}; mm = '{default: '0};
      ph = 0; rpc = 32'd0;
    end else if (ph == 0) begin
      if (exc_occur && mm.v) begin
        md.v = 1'b0; me.v = 1'b0; mm.v = 1'b0;
        ph = 1; rpc = cp0_pc;
      end else if (!pipe_stall) begin
        mm = me; mm.ov = ex_ov; mm.adel = ex_adel; mm.ades = ex_ades; mm.bad = ex_badvaddr;
        me = md; me.ri = id_ri; me.sys = id_sys; me.bp = id_bp; me.er = id_eret;
        md = '{default: '0}; md.v = if_valid; md.pc = if_pc; md.ds = if_is_in_ds;
      end
    end else if (ph == 1) ph = 2;
    else if (redirect_ready) ph = 0;
  endtask

  task automatic compare_all();
    bit        exc, er;
    bit [4:0]  code;
    bit [31:0] bad;
    resolve(mm, exc, code, bad, er);
    check("pre_is_exc", pre_is_exc, mm.v && exc);
    check("pre_is_eret", pre_is_eret, mm.v && er);
    check("reg_valid", reg_valid, mm.v && ph == 0);
    check("flush", flush, ph == 1);
    check("redirect_valid", redirect_valid, ph == 2);
    check("redirect_pc", redirect_pc, rpc);
    if (mm.v) begin
      check("pre_pc", pre_pc, mm.pc);
      check("cur_pc", cur_pc, mm.pc);
      check("pre_is_in_ds", pre_is_in_ds, mm.ds);
      check("cur_is_in_ds", cur_is_in_ds, mm.ds);
    end
    if (mm.v && exc && !er) check("pre_excCode", pre_excCode, code);
    if (mm.v && exc && (code == 5'd4 || code == 5'd5)) check("pre_badvaddr", pre_badvaddr, bad);
`ifndef ADDR_EXC_EN
    check("badvaddr_zero", pre_badvaddr, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 0; if_is_in_ds = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0;
    ex_ov = 0; ex_adel = 0; ex_ades = 0; ex_badvaddr = 0; pipe_stall = 0;
    exc_occur = 0; cp0_pc = 0; redirect_ready = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    check("rst_pre_pc", pre_pc, 32'd0);
    check("rst_excCode", pre_excCode, 32'd0);
    check("rst_reg_valid", reg_valid, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 0;
    // clean flow
    if_valid = 1; if_pc = 32'h100; tick();
    if_valid = 0; tick(); tick();
    check("clean_pc", pre_pc, 32'h100);
    check("clean_exc", pre_is_exc, 32'd0);
    check("clean_rv", reg_valid, 32'd1);
    // RI in D then Ov in E: RI wins, then flush/redirect
    if_valid = 1; if_pc = 32'h200; tick();
    if_valid = 0; id_ri = 1; tick();
    id_ri = 0; ex_ov = 1; tick();
    ex_ov = 0;
    check("multi_code", pre_excCode, 32'd10);
    exc_occur = 1; cp0_pc = 32'hBFC00380; tick();
    exc_occur = 0;
    check("flush_on", flush, 32'd1);
    tick();
    check("flush_off", flush, 32'd0);
    check("redir_valid", redirect_valid, 32'd1);
    check("redir_pc", redirect_pc, 32'hBFC00380);
    tick();
    check("redir_hold", redirect_valid, 32'd1);
    redirect_ready = 1; tick();
    redirect_ready = 0;
    check("redir_done", redirect_valid, 32'd0);
    // misaligned fetch
    if_valid = 1; if_pc = 32'h102; tick();
    if_valid = 0; tick(); tick();
`ifdef ADDR_EXC_EN
    check("misalign_code", pre_excCode, 32'd4);
    check("misalign_bad", pre_badvaddr, 32'h102);
`else
    check("misalign_noexc", pre_is_exc, 32'd0);
`endif
    // store address error in a delay slot
    if_valid = 1; if_pc = 32'h300; if_is_in_ds = 1; tick();
    if_valid = 0; if_is_in_ds = 0; tick();
    ex_ades = 1; ex_badvaddr = 32'h2001; tick();
    ex_ades = 0;
    check("ades_ds", pre_is_in_ds, 32'd1);
`ifdef ADDR_EXC_EN
    check("ades_code", pre_excCode, 32'd5);
    check("ades_bad", pre_badvaddr, 32'h2001);
`else
    check("ades_noexc", pre_is_exc, 32'd0);
`endif
    // eret with stalled redirect handshake
    if_valid = 1; if_pc = 32'h500; tick();
    if_valid = 0; id_eret = 1; tick();
    id_eret = 0; tick();
    check("eret_flag", pre_is_eret, 32'd1);
    exc_occur = 1; cp0_pc = 32'h400; tick();
    exc_occur = 0; cp0_pc = 32'h0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("eret_hold_v", redirect_valid, 32'd1);
      check("eret_hold_pc", redirect_pc, 32'h400);
    end
    redirect_ready = 1; tick();
    redirect_ready = 0;
    // exception together with stall clears every stage
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = 32'h600 + 32'(4 * i); tick();
    end
    if_valid = 0; pipe_stall = 1; exc_occur = 1; cp0_pc = 32'h700; tick();
    pipe_stall = 0; exc_occur = 0;
    check("stall_exc_flush", flush, 32'd1);
    tick();
    redirect_ready = 1; tick();
    redirect_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_exc_empty", reg_valid, 32'd0);
    end
    // reset while in REDIRECT
    if_valid = 1; if_pc = 32'h800; tick();
    if_valid = 0; tick(); tick();
    exc_occur = 1; cp0_pc = 32'h1234; tick();
    exc_occur = 0; tick();
    reset = 1; tick();
    reset = 0;
    check("rst_redir_v", redirect_valid, 32'd0);
    if_valid = 1; if_pc = 32'h900; tick();
    if_valid = 0; tick(); tick();
    check("rst_redir_run", reg_valid, 32'd1);
    // exc_occur with M empty is ignored
    tick();
    exc_occur = 1; tick();
    exc_occur = 0;
    check("exc_empty_ignored", flush, 32'd0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if_valid       = 1'($urandom_range(0, 1));
      if_pc          = ($urandom & 32'hFFFFFFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      if_is_in_ds    = 1'($urandom_range(0, 1));
      id_ri          = $urandom_range(0, 7) == 0;
      id_sys         = $urandom_range(0, 7) == 0;
      id_bp          = $urandom_range(0, 7) == 0;
      id_eret        = !id_ri && !id_sys && !id_bp && $urandom_range(0, 7) == 0;
      ex_ov          = $urandom_range(0, 7) == 0;
      ex_adel        = $urandom_range(0, 5) == 0;
      ex_ades        = $urandom_range(0, 5) == 0;
      ex_badvaddr    = $urandom;
      pipe_stall     = $urandom_range(0, 4) == 0;
      exc_occur      = $urandom_range(0, 9) == 0;
      cp0_pc         = $urandom;
      redirect_ready = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
